load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_align.sv | 43 ++++
 rtl/load_store_unit.sv | 141 ++++++++++++++
 tb/tb_load_store_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the alignment check used at request acceptance.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE   = 2'd0,
        SZ_HALF   = 2'd1,
        SZ_WORD   = 2'd2,
        SZ_DOUBLE = 2'd3
    } lsu_size_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        RMW_READ = 3'd2,
        WRITE    = 3'd3,
        RESP     = 3'd4
    } lsu_state_e;

    // An access is aligned when the low log2(bytes) address bits are zero.
    function automatic logic misaligned(input logic [2:0] off, input lsu_size_e size);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            SZ_WORD: return |off[1:0];
            default: return |off;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane handling: extracts and extends load data from a 64-bit
// word, and merges right-aligned store data into a word for read-modify-write.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [63:0] rword_i,
    input  logic [2:0]  off_i,
    input  lsu_size_e   size_i,
    input  logic        unsigned_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] ldata_o,
    output logic [63:0] merged_o
);

    logic [5:0]  sh;
    logic [63:0] lane;
    logic [63:0] mask;

    assign sh = {off_i, 3'b000};

    // Shift the addressed lane down to bit 0 and extend it to 64 bits.
    always_comb begin
        lane = rword_i >> sh;
        case (size_i)
            SZ_BYTE: ldata_o = unsigned_i ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
            SZ_HALF: ldata_o = unsigned_i ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
            SZ_WORD: ldata_o = unsigned_i ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
            default: ldata_o = lane;
        endcase
    end

    // Replace only the addressed bytes of the old word with the low store bytes.
    always_comb begin
        case (size_i)
            SZ_BYTE: mask = 64'h0000_0000_0000_00FF;
            SZ_HALF: mask = 64'h0000_0000_0000_FFFF;
            SZ_WORD: mask = 64'h0000_0000_FFFF_FFFF;
            default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        merged_o = (rword_i & ~(mask << sh)) | ((wdata_i & mask) << sh);
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a 64-bit word memory with a
// combinational read port. Sub-word stores use a read-modify-write sequence.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [63:0] resp_rdata,
    output logic [63:0] mem_addr,
    output logic        mem_we,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    localparam logic [63:0] WORDS64 = 64'(MEM_WORDS);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [63:0] addr_q, addr_d;
    lsu_size_e   size_q, size_d;
    logic        uns_q, uns_d;
    logic        err_q, err_d;
    logic [63:0] rdata_q, rdata_d;
    // Holds the store data at acceptance; for sub-word stores it is replaced
    // by the merged word during RMW_READ so WRITE just drives it out.
    logic [63:0] wword_q, wword_d;

    logic        req_err;
    logic [63:0] ldata;
    logic [63:0] merged;

    assign req_err = misaligned(req_addr[2:0], lsu_size_e'(req_size))
                   || ({3'b000, req_addr[63:3]} >= WORDS64);

    lsu_align u_align (
        .rword_i    (mem_rdata),
        .off_i      (addr_q[2:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .wdata_i    (wword_q),
        .ldata_o    (ldata),
        .merged_o   (merged)
    );

    // State and latched request fields; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            wword_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            wword_q <= wword_d;
        end
    end

    // Next-state, datapath captures and Moore outputs per state.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        size_d     = size_q;
        uns_d      = uns_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        wword_d    = wword_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        mem_addr   = {3'b000, addr_q[63:3]};
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                mem_addr  = '0;
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    size_d  = lsu_size_e'(req_size);
                    uns_d   = req_unsigned;
                    err_d   = req_err;
                    wword_d = req_wdata;
                    rdata_d = '0;
                    if (req_err)
                        state_d = RESP;
                    else if (!req_we)
                        state_d = LOAD;
                    else if (lsu_size_e'(req_size) == SZ_DOUBLE)
                        state_d = WRITE;
                    else
                        state_d = RMW_READ;
                end
            end
            LOAD: begin
                rdata_d = ldata;
                state_d = RESP;
            end
            RMW_READ: begin
                wword_d = merged;
                state_d = WRITE;
            end
            WRITE: begin
                mem_we    = 1'b1;
                mem_wdata = wword_q;
                state_d   = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (we_q || err_q) ? 64'd0 : rdata_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

    localparam int MEM_WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_err;
    logic [63:0] resp_rdata;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    logic [63:0] mem [MEM_WORDS];
    int          we_cnt = 0;
    int          errors = 0;
    int          checks = 0;
    int          wec;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr < 64'(MEM_WORDS)) ? mem[mem_addr[9:0]] : 64'd0;

    always @(posedge clk) begin
        if (mem_we) begin
            we_cnt = we_cnt + 1;
            if (mem_addr < 64'(MEM_WORDS)) mem[mem_addr[9:0]] = mem_wdata;
        end
    end

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 64'd0;
        mem[2]    = 64'h8877_6655_4433_2211;
        mem[1023] = 64'hA5A5_5A5A_1234_5678;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a request in IDLE; returns just after the handshake edge N.
    task automatic issue(input logic we, input logic [63:0] addr, input logic [1:0] size,
                         input logic uns, input logic [63:0] wd);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wd;
        chk1("ready_before_accept", req_ready, 1'b1);
        tick;
        req_valid = 1'b0;
    endtask

    logic [63:0] b2b_addr [3];
    logic [1:0]  b2b_size [3];
    logic        b2b_uns  [3];
    logic [63:0] b2b_exp  [3];

    initial begin
        req_valid = 0; req_we = 0; req_addr = '0; req_size = '0; req_unsigned = 0; req_wdata = '0;
        rst = 1'b1;
        tick; tick;
        chk1("rst_ready", req_ready, 1'b1);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk1("rst_resp_err", resp_err, 1'b0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        rst = 1'b0;
        tick;

        // signed byte load of byte 7 of word 2
        issue(1'b0, 64'h17, 2'd0, 1'b0, 64'd0);
        chk1("lb_n1_valid", resp_valid, 1'b0);
        chk1("lb_n1_we", mem_we, 1'b0);
        chk1("lb_n1_ready", req_ready, 1'b0);
        chk("lb_n1_addr", mem_addr, 64'd2);
        tick;
        chk1("lb_n2_valid", resp_valid, 1'b1);
        chk1("lb_n2_err", resp_err, 1'b0);
        chk("lb_n2_data", resp_rdata, 64'hFFFF_FFFF_FFFF_FF88);
        tick;
        chk1("lb_n3_valid", resp_valid, 1'b0);
        chk1("lb_n3_ready", req_ready, 1'b1);
        chk("lb_n3_addr", mem_addr, 64'd0);

        // unsigned byte load
        issue(1'b0, 64'h17, 2'd0, 1'b1, 64'd0);
        tick;
        chk1("lbu_valid", resp_valid, 1'b1);
        chk("lbu_data", resp_rdata, 64'h0000_0000_0000_0088);
        tick;

        // signed word load of upper half of word 2
        issue(1'b0, 64'h14, 2'd2, 1'b0, 64'd0);
        tick;
        chk("lw_data", resp_rdata, 64'hFFFF_FFFF_8877_6655);
        tick;

        // half store via read-modify-write
        wec = we_cnt;
        issue(1'b1, 64'h12, 2'd1, 1'b0, 64'h1234_5678_9ABC_BEEF);
        chk1("sh_n1_we", mem_we, 1'b0);
        chk1("sh_n1_valid", resp_valid, 1'b0);
        tick;
        chk1("sh_n2_we", mem_we, 1'b1);
        chk("sh_n2_wdata", mem_wdata, 64'h8877_6655_BEEF_2211);
        chk("sh_n2_addr", mem_addr, 64'd2);
        chk1("sh_n2_valid", resp_valid, 1'b0);
        tick;
        chk1("sh_n3_valid", resp_valid, 1'b1);
        chk1("sh_n3_err", resp_err, 1'b0);
        chk("sh_n3_rdata", resp_rdata, 64'd0);
        chk1("sh_n3_we", mem_we, 1'b0);
        chk("sh_mem2", mem[2], 64'h8877_6655_BEEF_2211);
        chk("sh_we_count", 64'(we_cnt - wec), 64'd1);
        tick;

        // signed half load of the stored half
        issue(1'b0, 64'h12, 2'd1, 1'b0, 64'd0);
        tick;
        chk("lh_data", resp_rdata, 64'hFFFF_FFFF_FFFF_BEEF);
        tick;

        // double store writes straight away
        issue(1'b1, 64'h18, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF);
        chk1("sd_n1_we", mem_we, 1'b1);
        chk("sd_n1_wdata", mem_wdata, 64'h0123_4567_89AB_CDEF);
        chk("sd_n1_addr", mem_addr, 64'd3);
        chk1("sd_n1_valid", resp_valid, 1'b0);
        tick;
        chk1("sd_n2_valid", resp_valid, 1'b1);
        chk1("sd_n2_we", mem_we, 1'b0);
        tick;
        issue(1'b0, 64'h18, 2'd3, 1'b0, 64'd0);
        tick;
        chk("ld_data", resp_rdata, 64'h0123_4567_89AB_CDEF);
        tick;

        // misaligned store and out-of-range loads
        wec = we_cnt;
        issue(1'b1, 64'h11, 2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        chk1("mis_valid", resp_valid, 1'b1);
        chk1("mis_err", resp_err, 1'b1);
        chk("mis_rdata", resp_rdata, 64'd0);
        chk1("mis_we", mem_we, 1'b0);
        tick;
        chk1("mis_after_valid", resp_valid, 1'b0);
        issue(1'b0, 64'h2000, 2'd3, 1'b0, 64'd0);
        chk1("oor_d_valid", resp_valid, 1'b1);
        chk1("oor_d_err", resp_err, 1'b1);
        chk("oor_d_rdata", resp_rdata, 64'd0);
        tick;
        issue(1'b0, 64'h2000, 2'd0, 1'b1, 64'd0);
        chk1("oor_b_err", resp_err, 1'b1);
        tick;
        // last valid word is in range
        issue(1'b0, 64'h1FF8, 2'd3, 1'b0, 64'd0);
        chk1("last_n1_valid", resp_valid, 1'b0);
        tick;
        chk1("last_err", resp_err, 1'b0);
        chk("last_data", resp_rdata, 64'hA5A5_5A5A_1234_5678);
        tick;
        chk("err_we_count", 64'(we_cnt - wec), 64'd0);
        chk("err_mem2", mem[2], 64'h8877_6655_BEEF_2211);

        // reset while in RMW_READ
        wec = we_cnt;
        issue(1'b1, 64'h10, 2'd0, 1'b0, 64'h55);
        chk1("rr_n1_we", mem_we, 1'b0);
        rst = 1'b1;
        #1;
        chk1("rr_ready_async", req_ready, 1'b1);
        chk1("rr_valid_async", resp_valid, 1'b0);
        chk("rr_addr_async", mem_addr, 64'd0);
        tick; tick;
        rst = 1'b0;
        tick;
        chk1("rr_valid_1", resp_valid, 1'b0);
        chk1("rr_we_1", mem_we, 1'b0);
        chk1("rr_ready", req_ready, 1'b1);
        tick;
        chk1("rr_valid_2", resp_valid, 1'b0);
        chk("rr_we_count", 64'(we_cnt - wec), 64'd0);
        chk("rr_mem2", mem[2], 64'h8877_6655_BEEF_2211);

        // back-to-back loads with req_valid held high
        b2b_addr[0] = 64'h10; b2b_size[0] = 2'd3; b2b_uns[0] = 1'b0; b2b_exp[0] = 64'h8877_6655_BEEF_2211;
        b2b_addr[1] = 64'h18; b2b_size[1] = 2'd3; b2b_uns[1] = 1'b0; b2b_exp[1] = 64'h0123_4567_89AB_CDEF;
        b2b_addr[2] = 64'h13; b2b_size[2] = 2'd0; b2b_uns[2] = 1'b1; b2b_exp[2] = 64'h0000_0000_0000_00BE;
        req_valid = 1'b1;
        req_we    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_addr     = b2b_addr[k];
            req_size     = b2b_size[k];
            req_unsigned = b2b_uns[k];
            chk1("b2b_idle_ready", req_ready, 1'b1);
            chk1("b2b_idle_valid", resp_valid, 1'b0);
            tick;
            chk1("b2b_load_ready", req_ready, 1'b0);
            chk1("b2b_load_valid", resp_valid, 1'b0);
            tick;
            chk1("b2b_resp_ready", req_ready, 1'b0);
            chk1("b2b_resp_valid", resp_valid, 1'b1);
            chk("b2b_resp_data", resp_rdata, b2b_exp[k]);
            tick;
        end
        req_valid = 1'b0;
        tick;
        chk1("b2b_end_ready", req_ready, 1'b1);
        chk1("b2b_end_valid", resp_valid, 1'b0);
        tick;
        chk1("b2b_end_valid2", resp_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
